fetch_sequencer: RTL and testbench

Instruction-fetch controller between the program counter logic and the 128-word instruction memory. It owns the fetch PC and drives the memory address every cycle. Each fetched instruction is captured with its PC into a small queue, and entries leave the queue to decode through a valid/ready handshake. Branch/jump redirects flush the queue and restart fetch. A misaligned or out-of-range fetch address latches a sticky fault.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_sequencer.sv | 104 ++++++++++
 tb/tb_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN,
    FAULT
  } fetch_state_e;

  localparam logic [31:0] FETCH_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries; flush wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t         r_mem [DEPTH];
  logic [PtrW-1:0]      r_rd_ptr;
  logic [PtrW-1:0]      r_wr_ptr;
  logic [CntW-1:0]      r_count;

  logic w_do_pop;
  logic w_do_push;

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CntW'(DEPTH)) || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
    end
  end

  // Entry storage; contents past the head are never observed, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the fetch PC, queues fetched instructions, handles redirects and faults.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Enable,
  output logic [31:0]            FetchAddr,
  input  logic [31:0]            MemInstruction,
  input  logic                   RedirectValid,
  input  logic [31:0]            RedirectTarget,
  output logic                   OutValid,
  output logic [31:0]            OutInstruction,
  output logic [31:0]            OutPC,
  input  logic                   OutReady,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Fault
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam logic [31:0] LastPc = 32'(IMEM_WORDS * 4 - 4);

  fetch_state_e  r_state;
  logic [31:0]   r_pc;
  logic          r_fault;

  logic          w_run;
  logic          w_pop;
  logic          w_push;
  logic          w_flush;
  logic          w_target_ok;
  logic          w_full;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;
  logic [CntW-1:0] w_count;

  assign w_run       = (r_state == RUN);
  assign w_full      = (w_count == CntW'(DEPTH));
  assign w_target_ok = (RedirectTarget[1:0] == 2'b00) && (RedirectTarget <= LastPc);
  assign w_pop       = OutValid && OutReady;
  // Redirects are only honoured in RUN; they flush regardless of target legality.
  assign w_flush     = w_run && RedirectValid;
  assign w_push      = w_run && Enable && !RedirectValid && (!w_full || w_pop);

  assign w_entry.pc    = r_pc;
  assign w_entry.instr = MemInstruction;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Fetch PC, RUN/FAULT state and sticky fault flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (RedirectValid) begin
            if (w_target_ok) begin
              r_pc <= RedirectTarget;
            end else begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end
          end else if (w_push) begin
            // Last word is fetched normally, then fetch stops instead of wrapping.
            if (r_pc == LastPc) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_pc <= r_pc + FETCH_STEP;
            end
          end
        end
        FAULT: ;
        default: r_state <= FAULT;
      endcase
    end
  end

  assign FetchAddr      = r_pc;
  assign Count          = w_count;
  assign Fault          = r_fault;
  assign OutValid       = (w_count != '0);
  assign OutPC          = OutValid ? w_head.pc : 32'h0;
  assign OutInstruction = OutValid ? w_head.instr : 32'h0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a queue-based behavioural model.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] LAST  = 32'h1FC;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic        RedirectValid = 1'b0;
  logic        OutReady = 1'b0;
  logic [31:0] RedirectTarget = 32'h0;
  logic [31:0] MemInstruction;
  logic [31:0] FetchAddr;
  logic [31:0] OutInstruction;
  logic [31:0] OutPC;
  logic        OutValid;
  logic        Fault;
  logic [$clog2(DEPTH):0] Count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd512) return (a >> 2) * 3;
    return 32'hBAD0_BAD0;
  endfunction

  assign MemInstruction = mem_word(FetchAddr);

  fetch_sequencer #(
    .DEPTH      (DEPTH),
    .RESET_PC   (32'h0),
    .IMEM_WORDS (128)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Enable         (Enable),
    .FetchAddr      (FetchAddr),
    .MemInstruction (MemInstruction),
    .RedirectValid  (RedirectValid),
    .RedirectTarget (RedirectTarget),
    .OutValid       (OutValid),
    .OutInstruction (OutInstruction),
    .OutPC          (OutPC),
    .OutReady       (OutReady),
    .Count          (Count),
    .Fault          (Fault)
  );

  // Behavioural model: a plain queue of fetched entries plus PC and fault flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_fault;

  task automatic model_reset();
    m_q.delete();
    m_pc    = 32'h0;
    m_fault = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit rv, input logic [31:0] rt, input bit rdy);
    int unsigned occ;
    bit pop;
    ent_t e;
    occ = m_q.size();
    pop = (occ != 0) && rdy;
    if (!m_fault && rv) begin
      m_q.delete();
      if ((rt % 4 == 0) && (rt <= LAST)) m_pc = rt;
      else m_fault = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_fault && en && (occ < DEPTH || pop)) begin
        e.pc    = m_pc;
        e.instr = mem_word(m_pc);
        m_q.push_back(e);
        if (m_pc == LAST) m_fault = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Advance one clock edge; inputs must already be set. Returns 1 time unit after the edge.
  task automatic cycle();
    bit en, rv, rdy;
    logic [31:0] rt;
    en  = Enable;
    rv  = RedirectValid;
    rt  = RedirectTarget;
    rdy = OutReady;
    @(posedge Clk);
    model_step(en, rv, rt, rdy);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    Enable = 1'b0;
    RedirectValid = 1'b0;
    RedirectTarget = 32'h0;
    OutReady = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (FetchAddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", FetchAddr, 32'h0); end
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", OutValid); end
    n_tests++; if (OutInstruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", OutInstruction); end
    n_tests++; if (OutPC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", OutPC); end
    n_tests++; if (Count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", Count); end
    n_tests++; if (Fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", Fault); end
  endtask

  task automatic test_basic();
    apply_reset();
    Enable = 1'b1;
    OutReady = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      n_tests++; if (OutPC !== 32'(4 * (k - 1))) begin n_fail++; $display("FAIL basic_pc[%0d]: got %h expected %h", k, OutPC, 4 * (k - 1)); end
      n_tests++; if (OutInstruction !== 32'(3 * (k - 1))) begin n_fail++; $display("FAIL basic_instr[%0d]: got %h expected %h", k, OutInstruction, 3 * (k - 1)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    Enable = 1'b1;
    OutReady = 1'b0;
    repeat (5) cycle();
    n_tests++; if (Count !== 2'd2) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", Count); end
    n_tests++; if (FetchAddr !== 32'h8) begin n_fail++; $display("FAIL bp_addr: got %h expected 8", FetchAddr); end
    n_tests++; if (OutPC !== 32'h0) begin n_fail++; $display("FAIL bp_head: got %h expected 0", OutPC); end
    OutReady = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      n_tests++; if (OutPC !== 32'(4 * k)) begin n_fail++; $display("FAIL bp_drain_pc[%0d]: got %h expected %h", k, OutPC, 4 * k); end
      n_tests++; if (Count !== 2'd2) begin n_fail++; $display("FAIL bp_drain_count[%0d]: got %0d expected 2", k, Count); end
    end
  endtask

  task automatic test_redirect_full();
    OutReady = 1'b0;
    repeat (2) cycle();
    n_tests++; if (Count !== 2'd2) begin n_fail++; $display("FAIL rf_pre_count: got %0d expected 2", Count); end
    RedirectValid = 1'b1;
    RedirectTarget = 32'h40;
    cycle();
    RedirectValid = 1'b0;
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b expected 0", OutValid); end
    n_tests++; if (Count !== 2'd0) begin n_fail++; $display("FAIL rf_count: got %0d expected 0", Count); end
    n_tests++; if (FetchAddr !== 32'h40) begin n_fail++; $display("FAIL rf_addr: got %h expected 40", FetchAddr); end
    OutReady = 1'b1;
    cycle();
    n_tests++; if (OutPC !== 32'h40) begin n_fail++; $display("FAIL rf_pc: got %h expected 40", OutPC); end
    n_tests++; if (OutInstruction !== 32'h30) begin n_fail++; $display("FAIL rf_instr: got %h expected 30", OutInstruction); end
  endtask

  task automatic test_illegal_redirect(input logic [31:0] tgt);
    apply_reset();
    Enable = 1'b1;
    OutReady = 1'b1;
    repeat (3) cycle();
    RedirectValid = 1'b1;
    RedirectTarget = tgt;
    cycle();
    RedirectValid = 1'b0;
    n_tests++; if (Fault !== 1'b1) begin n_fail++; $display("FAIL ill_fault[%h]: got %b expected 1", tgt, Fault); end
    n_tests++; if (Count !== 2'd0) begin n_fail++; $display("FAIL ill_count[%h]: got %0d expected 0", tgt, Count); end
    n_tests++; if (FetchAddr !== 32'hC) begin n_fail++; $display("FAIL ill_addr[%h]: got %h expected c", tgt, FetchAddr); end
    repeat (3) cycle();
    RedirectValid = 1'b1;
    RedirectTarget = 32'h40;
    cycle();
    RedirectValid = 1'b0;
    cycle();
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL ill_later_valid[%h]: got %b expected 0", tgt, OutValid); end
    n_tests++; if (FetchAddr !== 32'hC) begin n_fail++; $display("FAIL ill_later_addr[%h]: got %h expected c", tgt, FetchAddr); end
    n_tests++; if (Fault !== 1'b1) begin n_fail++; $display("FAIL ill_later_fault[%h]: got %b expected 1", tgt, Fault); end
  endtask

  task automatic test_end_of_mem();
    apply_reset();
    Enable = 1'b1;
    OutReady = 1'b1;
    RedirectValid = 1'b1;
    RedirectTarget = 32'h1F8;
    cycle();
    RedirectValid = 1'b0;
    n_tests++; if (FetchAddr !== 32'h1F8) begin n_fail++; $display("FAIL eom_addr0: got %h expected 1f8", FetchAddr); end
    cycle();
    n_tests++; if (OutPC !== 32'h1F8) begin n_fail++; $display("FAIL eom_pc0: got %h expected 1f8", OutPC); end
    n_tests++; if (OutInstruction !== 32'h17A) begin n_fail++; $display("FAIL eom_instr0: got %h expected 17a", OutInstruction); end
    n_tests++; if (Fault !== 1'b0) begin n_fail++; $display("FAIL eom_fault0: got %b expected 0", Fault); end
    cycle();
    n_tests++; if (OutPC !== 32'h1FC) begin n_fail++; $display("FAIL eom_pc1: got %h expected 1fc", OutPC); end
    n_tests++; if (OutInstruction !== 32'h17D) begin n_fail++; $display("FAIL eom_instr1: got %h expected 17d", OutInstruction); end
    n_tests++; if (Fault !== 1'b1) begin n_fail++; $display("FAIL eom_fault1: got %b expected 1", Fault); end
    n_tests++; if (FetchAddr !== 32'h1FC) begin n_fail++; $display("FAIL eom_addr1: got %h expected 1fc", FetchAddr); end
    repeat (3) cycle();
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL eom_drained: got %b expected 0", OutValid); end
    n_tests++; if (FetchAddr !== 32'h1FC) begin n_fail++; $display("FAIL eom_addr_hold: got %h expected 1fc", FetchAddr); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    Enable = 1'b1;
    OutReady = 1'b1;
    repeat (4) cycle();
    #2;
    Reset = 1'b0;
    #1;
    n_tests++; if (FetchAddr !== 32'h0) begin n_fail++; $display("FAIL ar_addr: got %h expected 0", FetchAddr); end
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b expected 0", OutValid); end
    n_tests++; if (OutPC !== 32'h0) begin n_fail++; $display("FAIL ar_pc: got %h expected 0", OutPC); end
    n_tests++; if (OutInstruction !== 32'h0) begin n_fail++; $display("FAIL ar_instr: got %h expected 0", OutInstruction); end
    n_tests++; if (Count !== 2'd0) begin n_fail++; $display("FAIL ar_count: got %0d expected 0", Count); end
    #2;
    Reset = 1'b1;
    model_reset();
    cycle();
    n_tests++; if (OutValid !== 1'b1 || OutPC !== 32'h0) begin n_fail++; $display("FAIL ar_restart: got valid %b pc %h expected valid 1 pc 0", OutValid, OutPC); end
    n_tests++; if (FetchAddr !== 32'h4) begin n_fail++; $display("FAIL ar_restart_addr: got %h expected 4", FetchAddr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_instr;
    bit exp_valid;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_fault && m_q.size() == 0 && $urandom_range(0, 3) == 0) apply_reset();
      Enable = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 2) != 0);
      RedirectValid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0: RedirectTarget = (32'($urandom_range(0, 127)) << 2) | 32'(1 + $urandom_range(0, 2));
        1: RedirectTarget = 32'h200 + (32'($urandom_range(0, 15)) << 2);
        2, 3: RedirectTarget = 32'h1F0 + (32'($urandom_range(0, 3)) << 2);
        default: RedirectTarget = 32'($urandom_range(0, 127)) << 2;
      endcase
      cycle();
      exp_valid = (m_q.size() != 0);
      exp_pc    = exp_valid ? m_q[0].pc : 32'h0;
      exp_instr = exp_valid ? m_q[0].instr : 32'h0;
      n_tests++; if (OutValid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, OutValid, exp_valid); end
      n_tests++; if (OutPC !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, OutPC, exp_pc); end
      n_tests++; if (OutInstruction !== exp_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, OutInstruction, exp_instr); end
      n_tests++; if (Count !== 2'(m_q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, Count, m_q.size()); end
      n_tests++; if (FetchAddr !== m_pc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, FetchAddr, m_pc); end
      n_tests++; if (Fault !== m_fault) begin n_fail++; $display("FAIL rnd_fault[%0d]: got %b expected %b", i, Fault, m_fault); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_full();
    test_illegal_redirect(32'h42);
    test_illegal_redirect(32'h200);
    test_end_of_mem();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
